// File: rtl/byte_stream_rd_buf_if.sv
// Bundles the push-stream input, pull-read output and status/error signals of
// byte_stream_rd_buf. Master = producer/reader side, slave = the buffer.
interface byte_stream_rd_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  // Push: iv_data is taken on every cycle with i_data_wr=1; there is no backpressure.
  // Pull: each i_data_rd=1 cycle requests one byte. Its data arrives the next cycle
  // together with a single-cycle o_rd_vld.
  logic [DATA_W-1:0] iv_data;
  logic              i_data_wr;
  logic              i_data_rd;
  logic              i_err_clr;
  logic [DATA_W-1:0] ov_rd_data;
  logic              o_rd_vld;
  logic [ADDR_W:0]   ov_count;
  logic              o_empty;
  logic              o_full;
  logic              o_overflow;
  logic              o_underflow;

  modport master (
    output iv_data, i_data_wr, i_data_rd, i_err_clr,
    input  ov_rd_data, o_rd_vld, ov_count, o_empty, o_full, o_overflow, o_underflow
  );

  modport slave (
    input  iv_data, i_data_wr, i_data_rd, i_err_clr,
    output ov_rd_data, o_rd_vld, ov_count, o_empty, o_full, o_overflow, o_underflow
  );
endinterface

// File: rtl/byte_stream_rd_buf.sv
// Buffers a producer-paced byte push stream in a small FIFO and hands the bytes
// to a consumer through a one-cycle-latency pull interface.
module byte_stream_rd_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  byte_stream_rd_buf_if.slave  bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_vld_q, rd_vld_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              empty, full, rd_acc, wr_acc;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign rd_acc = bus.i_data_rd && !empty;
  // When full, a push is still taken if the read frees the entry in the same cycle.
  assign wr_acc = bus.i_data_wr && (!full || rd_acc);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_acc;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    // A new error event takes priority over a clear in the same cycle.
    if (bus.i_data_wr && !wr_acc) ovf_d = 1'b1;
    else if (bus.i_err_clr)       ovf_d = 1'b0;
    if (bus.i_data_rd && empty)   udf_d = 1'b1;
    else if (bus.i_err_clr)       udf_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= bus.iv_data;
  end

  assign bus.ov_rd_data  = rd_data_q;
  assign bus.o_rd_vld    = rd_vld_q;
  assign bus.ov_count    = count_q;
  assign bus.o_empty     = empty;
  assign bus.o_full      = full;
  assign bus.o_overflow  = ovf_q;
  assign bus.o_underflow = udf_q;
endmodule

// File: tb/tb_byte_stream_rd_buf.sv
// Testbench for byte_stream_rd_buf: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_byte_stream_rd_buf;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic i_clk;
  logic i_rst_n;
  byte_stream_rd_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  byte_stream_rd_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_data;
  logic              m_vld;
  logic              m_ovf;
  logic              m_udf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    exp_q.delete();
    m_data = '0;
    m_vld  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  function automatic logic [17:0] exp_vec();
    return {m_vld, m_data, 5'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH, m_ovf, m_udf};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {bus.o_rd_vld, bus.ov_rd_data, bus.ov_count, bus.o_empty, bus.o_full,
            bus.o_overflow, bus.o_underflow};
  endfunction

  // driver: called at a negedge, applies one cycle of inputs, advances the model
  // at the rising edge and returns at the next negedge for sampling
  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rd, input logic clr);
    logic had_data, rd_ok, wr_ok;
    bus.iv_data   = d;
    bus.i_data_wr = wr;
    bus.i_data_rd = rd;
    bus.i_err_clr = clr;
    @(posedge i_clk);
    had_data = (exp_q.size() != 0);
    rd_ok = rd && had_data;
    wr_ok = wr && (exp_q.size() < DEPTH || rd_ok);
    m_vld = rd_ok;
    if (rd_ok) m_data = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(d);
    if (wr && !wr_ok)       m_ovf = 1'b1;
    else if (clr)           m_ovf = 1'b0;
    if (rd && !had_data)    m_udf = 1'b1;
    else if (clr)           m_udf = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    bus.iv_data = '0; bus.i_data_wr = 1'b0; bus.i_data_rd = 1'b0; bus.i_err_clr = 1'b0;
    i_rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (obs_vec() !== 18'h0_0008) $display("FAIL reset_state obs=%h exp=%h", obs_vec(), 18'h0_0008);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] pat [3];
    pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, pat[i], 1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL basic_push i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus.o_rd_vld !== 1'b1 || bus.ov_rd_data !== pat[i] || bus.ov_count !== 5'(2 - i))
        $display("FAIL basic_read i=%0d vld=%b data=%h cnt=%0d exp_data=%h exp_cnt=%0d",
                 i, bus.o_rd_vld, bus.ov_rd_data, bus.ov_count, pat[i], 2 - i);
      else n_pass++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (obs_vec() !== exp_vec() || bus.o_empty !== 1'b1 || bus.o_rd_vld !== 1'b0)
      $display("FAIL basic_idle obs=%h exp=%h", obs_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    n_checks++;
    if (bus.o_full !== 1'b1 || bus.ov_count !== 5'd16 || bus.o_overflow !== 1'b0)
      $display("FAIL fill_full full=%b cnt=%0d ovf=%b exp=1/16/0", bus.o_full, bus.ov_count, bus.o_overflow);
    else n_pass++;
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    n_checks++;
    if (bus.o_full !== 1'b1 || bus.ov_count !== 5'd16 || bus.o_overflow !== 1'b1)
      $display("FAIL overflow_set full=%b cnt=%0d ovf=%b exp=1/16/1", bus.o_full, bus.ov_count, bus.o_overflow);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (bus.o_rd_vld !== 1'b1 || bus.ov_rd_data !== 8'(i) || obs_vec() !== exp_vec())
        $display("FAIL overflow_drain i=%0d data=%h exp=%h obs=%h expv=%h",
                 i, bus.ov_rd_data, 8'(i), obs_vec(), exp_vec());
      else n_pass++;
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (bus.o_overflow !== 1'b0 || bus.o_empty !== 1'b1)
      $display("FAIL overflow_clr ovf=%b empty=%b exp=0/1", bus.o_overflow, bus.o_empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    step(1'b1, 8'hC0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.ov_count !== 5'd1 || bus.o_rd_vld !== 1'b1)
        $display("FAIL b2b i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.ov_rd_data !== 8'd39 || obs_vec() !== exp_vec())
      $display("FAIL b2b_last data=%h exp=%h", bus.ov_rd_data, 8'd39);
    else n_pass++;
  endtask

  task automatic test_full_rw();
    logic [7:0] first;
    first = 8'($urandom_range(0, 255));
    step(1'b1, first, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    n_checks++;
    if (bus.o_rd_vld !== 1'b1 || bus.ov_rd_data !== first || bus.ov_count !== 5'd16 ||
        bus.o_overflow !== 1'b0)
      $display("FAIL full_rw vld=%b data=%h cnt=%0d ovf=%b exp=1/%h/16/0",
               bus.o_rd_vld, bus.ov_rd_data, bus.ov_count, bus.o_overflow, first);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL full_rw_drain i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (bus.ov_rd_data !== 8'h5A) $display("FAIL full_rw_tail data=%h exp=5a", bus.ov_rd_data);
    else n_pass++;
  endtask

  task automatic test_empty_rw();
    step(1'b1, 8'h77, 1'b1, 1'b0);
    n_checks++;
    if (bus.o_rd_vld !== 1'b0 || bus.o_underflow !== 1'b1 || bus.ov_count !== 5'd1)
      $display("FAIL empty_rw vld=%b udf=%b cnt=%0d exp=0/1/1", bus.o_rd_vld, bus.o_underflow, bus.ov_count);
    else n_pass++;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.o_rd_vld !== 1'b1 || bus.ov_rd_data !== 8'h77 || bus.o_underflow !== 1'b1)
      $display("FAIL empty_rw_read vld=%b data=%h udf=%b exp=1/77/1", bus.o_rd_vld, bus.ov_rd_data, bus.o_underflow);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if (bus.o_underflow !== 1'b0 || obs_vec() !== exp_vec())
      $display("FAIL underflow_clr udf=%b exp=0", bus.o_underflow);
    else n_pass++;
    // set beats clear in the same cycle
    step(1'b0, 8'h00, 1'b1, 1'b1);
    n_checks++;
    if (bus.o_underflow !== 1'b1) $display("FAIL udf_set_wins udf=%b exp=1", bus.o_underflow);
    else n_pass++;
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic wr, rd, clr;
    for (int i = 0; i < 400; i++) begin
      wr  = ($urandom_range(0, 9) < 6);
      rd  = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 19) == 0);
      step(wr, 8'($urandom), rd, clr);
      n_checks++;
      if (obs_vec() !== exp_vec())
        $display("FAIL random i=%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    while (exp_q.size() != 0) step(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    step(1'b1, 8'hE1, 1'b1, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (obs_vec() !== 18'h0_0008) $display("FAIL async_reset obs=%h exp=%h", obs_vec(), 18'h0_0008);
    else n_pass++;
    bus.i_data_wr = 1'b0; bus.i_data_rd = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1'b1, 8'h42, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if (bus.o_rd_vld !== 1'b1 || bus.ov_rd_data !== 8'h42 || obs_vec() !== exp_vec())
      $display("FAIL post_reset_read vld=%b data=%h exp=1/42", bus.o_rd_vld, bus.ov_rd_data);
    else n_pass++;
  endtask

  initial begin
    i_rst_n = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_full_rw();
    test_empty_rw();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
